// File: rtl/mesh_stream_feeder_pkg.sv
// mesh_stream_feeder_pkg: shared feeder state encoding and mesh data width
package mesh_stream_feeder_pkg;

    localparam int MESH_WIDTH = 32;

    typedef enum logic [1:0] {FD_IDLE, FD_STREAM, FD_DONE} feeder_state_t;

endpackage

// File: rtl/mesh_stream_feeder_if.sv
// mesh_stream_feeder_if: AXI-Stream link from the feeder into the mesh system input
interface mesh_stream_feeder_if
    import mesh_stream_feeder_pkg::*;
#(
    parameter int WIDTH = MESH_WIDTH
);

    logic [WIDTH-1:0] m_tdata;
    logic             m_tvalid;
    logic             m_tready;
    logic             m_tlast;

    modport master (output m_tdata, m_tvalid, m_tlast, input m_tready);
    modport slave  (input m_tdata, m_tvalid, m_tlast, output m_tready);

endinterface

// File: rtl/mesh_stream_feeder_axis_out_reg.sv
// axis_out_reg: single-entry AXI-Stream master output register with load and clear
module axis_out_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             last_i,
    input  logic             tready_i,
    output logic [WIDTH-1:0] tdata_o,
    output logic             tlast_o,
    output logic             tvalid_o,
    output logic             load_en_o
);

    logic [WIDTH-1:0] data_q;
    logic             last_q;
    logic             valid_q;

    assign load_en_o = !valid_q || tready_i;
    assign tdata_o   = data_q;
    assign tlast_o   = last_q;
    assign tvalid_o  = valid_q;

    // Register only moves when empty or its word is being taken; load wins over clear
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (load_en_o) begin
            if (load_i) begin
                data_q  <= data_i;
                last_q  <= last_i;
                valid_q <= 1'b1;
            end else if (clear_i) begin
                last_q  <= 1'b0;
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mesh_stream_feeder.sv
// mesh_stream_feeder: buffers a host-loaded tile and streams its first len words to the mesh
module mesh_stream_feeder
    import mesh_stream_feeder_pkg::*;
#(
    parameter int WIDTH = MESH_WIDTH,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    input  logic [LW-1:0]    len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    mesh_stream_feeder_if.master m
);

    feeder_state_t    state_q;
    logic [LW-1:0]    lc_q;
    logic [LW-1:0]    cnt_q;
    logic             abort_q;
    logic             aborted_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [LW-1:0]    lc_d;
    logic [LW-1:0]    nxt;
    logic             idle;
    logic             hs;
    logic             final_beat;
    logic             stop;
    logic             load;
    logic             clear;
    logic             load_en;
    logic             ld_last;
    logic [WIDTH-1:0] ld_data;

    assign busy    = state_q == FD_STREAM;
    assign done    = state_q == FD_DONE;
    assign aborted = aborted_q;

    // Next-word selection: word 0 on start, word cnt+1 after each handshake unless stopping
    always_comb begin
        lc_d       = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
        nxt        = cnt_q + 1'b1;
        idle       = state_q == FD_IDLE;
        hs         = m.m_tvalid && m.m_tready;
        final_beat = hs && (nxt == lc_q);
        stop       = busy && hs && (final_beat || abort_q || abort);
        load       = load_en && (idle ? (start && lc_d != '0) : (busy && hs && !stop));
        clear      = stop;
        ld_data    = idle ? mem_q[0] : mem_q[nxt[AW-1:0]];
        ld_last    = idle ? (lc_d == LW'(1)) : (nxt == lc_q - LW'(1));
    end

    axis_out_reg #(.WIDTH(WIDTH)) u_out (
        .clk      (aclk),
        .rst      (areset),
        .load_i   (load),
        .clear_i  (clear),
        .data_i   (ld_data),
        .last_i   (ld_last),
        .tready_i (m.m_tready),
        .tdata_o  (m.m_tdata),
        .tlast_o  (m.m_tlast),
        .tvalid_o (m.m_tvalid),
        .load_en_o(load_en)
    );

    // Tile buffer is writable only while idle so a running transfer sees a frozen tile
    always_ff @(posedge aclk) begin
        if (idle && wr_en) mem_q[wr_addr] <= wr_data;
    end

    // Transfer control: length latch, beat index, sticky abort and completion status
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= FD_IDLE;
            lc_q      <= '0;
            cnt_q     <= '0;
            abort_q   <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            case (state_q)
                FD_IDLE: begin
                    if (start) begin
                        lc_q      <= lc_d;
                        cnt_q     <= '0;
                        aborted_q <= 1'b0;
                        state_q   <= (lc_d == '0) ? FD_DONE : FD_STREAM;
                    end
                end
                FD_STREAM: begin
                    if (stop) begin
                        state_q   <= FD_DONE;
                        aborted_q <= !final_beat;
                    end else begin
                        if (hs) cnt_q <= nxt;
                        if (abort) abort_q <= 1'b1;
                    end
                end
                FD_DONE: begin
                    state_q   <= FD_IDLE;
                    abort_q   <= 1'b0;
                    aborted_q <= 1'b0;
                end
                default: state_q <= FD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mesh_stream_feeder.sv
// tb_mesh_stream_feeder: scoreboard bench for the tile stream feeder against a buffer model
module tb_mesh_stream_feeder;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        start = 1'b0;
    logic [4:0]  len = '0;
    logic        abort = 1'b0;
    logic        busy, done, aborted;

    mesh_stream_feeder_if #(.WIDTH(32)) sif ();

    mesh_stream_feeder #(.WIDTH(32), .DEPTH(16)) dut (
        .aclk   (aclk),
        .areset (areset),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .start  (start),
        .len    (len),
        .abort  (abort),
        .busy   (busy),
        .done   (done),
        .aborted(aborted),
        .m      (sif.master)
    );

    always #5 aclk = ~aclk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] model [16];
    logic [32:0] exp_beats [$];
    logic        exp_ab [$];
    logic        stall_arm = 1'b0;
    logic [31:0] sd = '0;
    logic        sl = 1'b0;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    // Monitor: pops expected beats on handshakes and expected status on done
    always @(negedge aclk) begin
        if (areset) begin
            stall_arm <= 1'b0;
        end else begin
            if (stall_arm) chk("stall_hold", {sif.m_tvalid, sif.m_tlast, sif.m_tdata}, {1'b1, sl, sd});
            if (sif.m_tvalid && sif.m_tready) begin
                if (exp_beats.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_beat: got %0h expected no beat", {sif.m_tlast, sif.m_tdata});
                end else begin
                    chk("beat", {sif.m_tlast, sif.m_tdata}, exp_beats.pop_front());
                end
            end
            stall_arm <= sif.m_tvalid && !sif.m_tready;
            sd <= sif.m_tdata;
            sl <= sif.m_tlast;
            if (done) begin
                chk("busy_in_done", busy, 0);
                if (exp_ab.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_done: got done expected none");
                end else begin
                    chk("aborted", aborted, exp_ab.pop_front());
                end
            end
        end
    end

    task automatic wr(input int a, input logic [31:0] d);
        @(posedge aclk); #1;
        wr_en = 1'b1;
        wr_addr = 4'(a);
        wr_data = d;
        model[a] = d;
        @(posedge aclk); #1;
        wr_en = 1'b0;
    endtask

    // mode: 0 ready high, 1 random ready, 2 ready pattern 1,0,0
    task automatic run(input int len_v, input int ab_k, input int mode, input int stall_at, input int rst_at);
        int lc, kk, cyc, h, stalls, last_hs, exp_done;
        bit sent, fin, rst_pend, busy_seen;
        lc = (len_v > 16) ? 16 : len_v;
        if (rst_at >= 0) kk = rst_at;
        else begin
            kk = (ab_k >= 0 && ab_k < lc) ? ab_k + 1 : lc;
            exp_ab.push_back(ab_k >= 0 && ab_k < lc - 1);
        end
        for (int i = 0; i < kk; i++) exp_beats.push_back({i == lc - 1, model[i]});
        @(posedge aclk); #1;
        start = 1'b1;
        len = 5'(len_v);
        sif.m_tready = 1'b1;
        cyc = 0; h = 0; stalls = 0; last_hs = -1;
        sent = 0; fin = 0; rst_pend = 0; busy_seen = 0;
        while (!fin && cyc < 300) begin
            @(posedge aclk); #1;
            start = 1'b0; abort = 1'b0; areset = 1'b0; wr_en = 1'b0;
            if (cyc == 0) chk("first_valid", sif.m_tvalid, lc > 0);
            if (busy) busy_seen = 1;
            if (rst_pend) begin
                chk("reset_outputs", {sif.m_tvalid, sif.m_tlast, sif.m_tdata, busy, done, aborted}, 0);
                fin = 1;
            end else if (done) begin
                exp_done = (kk == 0) ? 0 : last_hs + 1;
                chk("done_latency", cyc, exp_done);
                if (mode == 0 && ab_k < 0 && stall_at < 0) chk("throughput", cyc, lc);
                fin = 1;
            end else begin
                sif.m_tready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (cyc % 3 == 0);
                if (h == stall_at && stalls < 3 && sif.m_tvalid) begin
                    sif.m_tready = 1'b0;
                    stalls++;
                end
                if (rst_at >= 0 && sif.m_tvalid && h == rst_at) begin
                    areset = 1'b1;
                    sif.m_tready = 1'b0;
                    rst_pend = 1;
                end else begin
                    if (sif.m_tvalid && h == ab_k && !sent) begin
                        abort = 1'b1;
                        sent = 1;
                    end
                    if (busy && $urandom_range(0, 2) == 0) begin
                        wr_en = 1'b1;
                        wr_addr = 4'($urandom_range(0, 15));
                        wr_data = $urandom;
                    end
                    if (sif.m_tvalid && sif.m_tready) begin
                        h++;
                        last_hs = cyc;
                    end
                end
            end
            cyc++;
        end
        start = 1'b0; abort = 1'b0; areset = 1'b0; wr_en = 1'b0;
        if (!fin) begin
            tests++;
            fails++;
            $display("FAIL timeout: got no completion expected done within 300 cycles");
            exp_beats.delete();
            exp_ab.delete();
        end
        if (lc == 0) chk("busy_never", busy_seen, 0);
    endtask

    initial begin
        sif.m_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        chk("reset_state", {sif.m_tvalid, sif.m_tlast, sif.m_tdata, busy, done, aborted}, 0);
        areset = 1'b0;
        for (int i = 0; i < 16; i++) wr(i, 32'h100 + i);
        run(4, -1, 0, -1, -1);
        run(5, -1, 2, -1, -1);
        run(0, -1, 0, -1, -1);
        run(20, -1, 0, -1, -1);
        run(8, 2, 0, 2, -1);
        run(8, -1, 0, -1, 3);
        run(2, -1, 0, -1, -1);
        run(16, -1, 1, -1, -1);
        run(6, 5, 1, -1, -1);
        for (int t = 0; t < 25; t++) begin
            int n, lv, ak;
            n = $urandom_range(0, 5);
            for (int j = 0; j < n; j++) wr($urandom_range(0, 15), $urandom);
            lv = $urandom_range(0, 20);
            ak = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 17) : -1;
            run(lv, ak, $urandom_range(0, 2), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : -1, -1);
        end
        repeat (3) @(posedge aclk);
        #1;
        chk("beats_drained", exp_beats.size(), 0);
        chk("dones_drained", exp_ab.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mesh_stream_feeder.md
Name: mesh_stream_feeder

Overview:
- AXI-Stream transmitter that drives the mesh system input stream (sys_in_tdata/tvalid/tready).
- Host loads a tile of words into a small internal buffer through a simple write port, then pulses start.
- Block streams the first len words out, one per cycle under full backpressure, with tlast on the final word.
- Supports clean abort and reports done and aborted status.

Parameters:
- WIDTH, 32, data word width; must match mesh WIDTH.
- DEPTH, 16, buffer depth in words; power of two, at least 2.
- AW, $clog2(DEPTH), buffer address width.
- LW, $clog2(DEPTH+1), length field width.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  AW  buffer write address.
- wr_data  in  WIDTH  buffer write data.
- start  in  1  begin streaming; sampled in IDLE only.
- len  in  LW  word count, sampled with start.
- abort  in  1  stop after the outstanding beat.
- busy  out  1  high in STREAM.
- done  out  1  one-cycle pulse at end of a transfer.
- aborted  out  1  valid with done; 1 if the transfer ended by abort.
- m_tdata  out  WIDTH  stream data to mesh.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready from mesh.
- m_tlast  out  1  final word of transfer.

Behaviour:
- Reset (areset=1 sampled at edge):
  - state=IDLE.
  - busy, done, aborted, m_tvalid, m_tlast are 0; m_tdata is 0.
  - Read pointer and beat count are 0.
  - Buffer contents are not reset.
  - Reset mid-stream drops m_tvalid on that edge with no done pulse; this is the only permitted un-handshaked tvalid drop.
- States: IDLE, STREAM, DONE.
- IDLE:
  - wr_en writes buf[wr_addr]=wr_data at the edge.
  - start=1 latches Lc=min(len,DEPTH).
  - If Lc=0, go to DONE with no beats.
  - Otherwise go to STREAM and load the output register with buf[0], so m_tvalid=1 in the cycle after start.
  - m_tlast=(Lc==1).
- STREAM:
  - Output register updates only when !m_tvalid || m_tready.
  - On handshake (m_tvalid & m_tready) of word k<Lc-1: load buf[k+1], m_tvalid stays 1, m_tlast=(k+1==Lc-1). Throughput is 1 word/cycle when m_tready is held high.
  - On handshake of word Lc-1: m_tvalid←0, m_tlast←0, go to DONE.
  - m_tdata, m_tlast are stable while m_tvalid & !m_tready. m_tvalid never drops without a handshake.
  - wr_en is ignored in STREAM (buffer write-protected); start is ignored.
- Abort:
  - abort=1 in STREAM sets a sticky abort_req.
  - At the next handshake (or the same cycle, if a handshake coincides), no further word is loaded: m_tvalid←0, go to DONE with aborted=1.
  - The handshaked word keeps its tlast value; tlast is not forced.
  - Abort in IDLE or DONE is ignored.
  - Abort coinciding with the final handshake gives aborted=0 (transfer was complete).
- DONE: exactly one cycle.
  - done=1, busy=0, aborted per above.
  - Then go to IDLE and clear abort_req.
  - start in DONE is ignored.
- busy=1 exactly while state=STREAM.
- Latency: start edge to first m_tvalid is 1 cycle. Final handshake to done is 1 cycle.
- Widths:
  - len values above DEPTH are clamped.
  - Beat counter is LW bits and never wraps within a transfer.
  - wr_addr is AW bits, so every address is in range.

Decomposition:
- mesh_pkg holds:
  - typedef enum logic [1:0] {FD_IDLE, FD_STREAM, FD_DONE} feeder_state_t;
  - default WIDTH constant, shared with mesh_top.
- One sub-module: axis_out_reg, a single-entry master output register. It holds tdata/tlast/tvalid, exposes load_en=!tvalid||tready, and provides a clear for the final/abort beat. It is reusable for a later result collector's output side.

Test Plan:
- Load buf[i]=0x100+i (i=0..15), start with len=4, m_tready=1 → words 0x100..0x103 on 4 consecutive cycles starting 1 cycle after start; tlast only on 0x103; done 1 cycle after the last beat; aborted=0.
- Same load, len=5, m_tready toggling 1,0,0,1,... → all 5 words delivered in order with no duplicates; tdata/tlast stable during each stall.
- Start with len=0 → no m_tvalid; done pulses the cycle after start; busy never rises.
- Start with len=20 (DEPTH=16) → exactly 16 beats (0x100..0x10F); tlast on 0x10F.
- len=8 with abort during word 2, m_tready=0 for 3 cycles → word 2 transferred after stall; no word 3; done=1 and aborted=1 the next cycle.
- areset mid-stream after 3 beats → next cycle all outputs 0 and state IDLE. A fresh start with len=2 then emits buf[0], buf[1] normally. wr_en during STREAM leaves the buffer unchanged, checked on a replay.
